duck_motion_ctl: RTL and testbench

- Sequences one duck sprite's position through its life: spawn, horizontal flight, hit freeze, gravity fall, landed hold, and back to idle.
- Turns the mouse click into a shot. A hit is a rising edge of mouse_left with the cursor inside the duck's box.
- Sits between the mouse decoder and the sprite draw stage, and feeds that stage xpos/ypos (top-left corner).
- Replaces ad-hoc combinational state updates with a registered FSM and a fixed-point integrator.

---
 rtl/duck_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/duck_motion_ctl.sv | 192 +++++++++++++++++++
 tb/tb_duck_motion_ctl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared state codes, fixed-point width and screen defaults for the duck controller
package duck_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FLY  = 3'd1;
  localparam logic [2:0] ST_HIT  = 3'd2;
  localparam logic [2:0] ST_FALL = 3'd3;
  localparam logic [2:0] ST_DOWN = 3'd4;

  localparam int Q8_W = 8;

  localparam int DEF_H_RES = 800;
  localparam int DEF_V_RES = 600;
  localparam int DEF_PIC_W = 64;
  localparam int DEF_PIC_H = 64;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running divider emitting a one-cycle tick every MS_DIV cycles
module ms_tick_gen #(
  parameter int MS_DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // clr restarts the period so the first tick lands MS_DIV cycles after it
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/duck_motion_ctl.sv
// rtl/duck_motion_ctl.sv - duck sprite life-cycle FSM: spawn, fly, hit freeze, gravity fall, landed hold
module duck_motion_ctl
  import duck_pkg::*;
#(
  parameter int MS_DIV  = 100_000,
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int PIC_W   = DEF_PIC_W,
  parameter int PIC_H   = DEF_PIC_H,
  parameter int FLY_DX  = 1,
  parameter int GRAV    = 8,
  parameter int HIT_MS  = 300,
  parameter int DOWN_MS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] spawn_x,
  input  logic [11:0] spawn_y,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [2:0]  state,
  output logic        hit,
  output logic        landed,
  output logic        busy
);

  localparam int MS_W = 16;
  localparam logic [11:0]     X_MAX    = 12'(H_RES - PIC_W);
  localparam logic [11:0]     Y_MAX    = 12'(V_RES - PIC_H);
  localparam logic [12:0]     PIC_W13  = 13'(PIC_W);
  localparam logic [12:0]     PIC_H13  = 13'(PIC_H);
  localparam logic [11:0]     DX       = 12'(FLY_DX);
  localparam logic [16:0]     GRAV17   = 17'(GRAV);
  localparam logic [MS_W-1:0] HIT_LAST  = MS_W'(HIT_MS - 1);
  localparam logic [MS_W-1:0] DOWN_LAST = MS_W'(DOWN_MS - 1);

  logic [2:0]      state_q, state_d;
  logic [11:0]     xpos_q, xpos_d;
  logic [11:0]     ypos_q, ypos_d;
  logic            dir_q, dir_d;
  logic [15:0]     vel_q, vel_d;
  logic [19:0]     yfix_q, yfix_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            ml_dly_q, ml_dly_d;
  logic            hit_q, hit_d;
  logic            landed_q, landed_d;

  logic        tick, clr, click, in_box;
  logic [12:0] x_right;
  logic [16:0] vel_sum;
  logic [15:0] vel_next;
  logic [20:0] y_sum;

  ms_tick_gen #(.MS_DIV(MS_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign click  = mouse_left & ~ml_dly_q;
  assign in_box = ({1'b0, xpos_q} <= {1'b0, mouse_xpos}) &&
                  ({1'b0, mouse_xpos} < ({1'b0, xpos_q} + PIC_W13)) &&
                  ({1'b0, ypos_q} <= {1'b0, mouse_ypos}) &&
                  ({1'b0, mouse_ypos} < ({1'b0, ypos_q} + PIC_H13));

  assign x_right  = {1'b0, xpos_q} + {1'b0, DX};
  assign vel_sum  = {1'b0, vel_q} + GRAV17;
  assign vel_next = vel_sum[16] ? 16'hFFFF : vel_sum[15:0];
  assign y_sum    = {1'b0, yfix_q} + {5'b0, vel_next};

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    dir_d    = dir_q;
    vel_d    = vel_q;
    yfix_d   = yfix_q;
    ms_cnt_d = ms_cnt_q;
    ml_dly_d = mouse_left;
    hit_d    = 1'b0;
    landed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xpos_d  = clamp12(spawn_x, X_MAX);
          ypos_d  = clamp12(spawn_y, Y_MAX);
          dir_d   = 1'b0;
          state_d = ST_FLY;
        end
      end
      ST_FLY: begin
        // a hit takes priority over a same-cycle tick, so the box test sees the pre-tick xpos
        if (click && in_box) begin
          hit_d   = 1'b1;
          state_d = ST_HIT;
        end else if (tick) begin
          if (!dir_q) begin
            if (x_right >= {1'b0, X_MAX}) begin
              xpos_d = X_MAX;
              dir_d  = 1'b1;
            end else begin
              xpos_d = x_right[11:0];
            end
          end else begin
            if (xpos_q <= DX) begin
              xpos_d = '0;
              dir_d  = 1'b0;
            end else begin
              xpos_d = xpos_q - DX;
            end
          end
        end
      end
      ST_HIT: begin
        if (tick) begin
          if (ms_cnt_q == HIT_LAST) begin
            state_d = ST_FALL;
            vel_d   = '0;
            yfix_d  = {ypos_q, {Q8_W{1'b0}}};
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      ST_FALL: begin
        if (tick) begin
          vel_d = vel_next;
          if (y_sum[20:8] >= {1'b0, Y_MAX}) begin
            ypos_d   = Y_MAX;
            yfix_d   = {Y_MAX, {Q8_W{1'b0}}};
            landed_d = 1'b1;
            state_d  = ST_DOWN;
          end else begin
            yfix_d = y_sum[19:0];
            ypos_d = y_sum[19:8];
          end
        end
      end
      ST_DOWN: begin
        if (tick) begin
          if (ms_cnt_q == DOWN_LAST) state_d = ST_IDLE;
          else                       ms_cnt_d = ms_cnt_q + MS_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) ms_cnt_d = '0;
  end

  assign clr = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      xpos_q   <= '0;
      ypos_q   <= '0;
      dir_q    <= 1'b0;
      vel_q    <= '0;
      yfix_q   <= '0;
      ms_cnt_q <= '0;
      ml_dly_q <= 1'b0;
      hit_q    <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      dir_q    <= dir_d;
      vel_q    <= vel_d;
      yfix_q   <= yfix_d;
      ms_cnt_q <= ms_cnt_d;
      ml_dly_q <= ml_dly_d;
      hit_q    <= hit_d;
      landed_q <= landed_d;
    end
  end

  assign xpos   = xpos_q;
  assign ypos   = ypos_q;
  assign state  = state_q;
  assign hit    = hit_q;
  assign landed = landed_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_duck_motion_ctl.sv
// tb/tb_duck_motion_ctl.sv - scenario bench for duck_motion_ctl with a queue of expected positions
module tb_duck_motion_ctl;

  localparam int MS_DIV  = 10;
  localparam int GRAV    = 256;
  localparam int HIT_MS  = 3;
  localparam int DOWN_MS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] spawn_x = '0, spawn_y = '0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic [2:0]  state;
  logic        hit, landed, busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  duck_motion_ctl #(
    .MS_DIV(MS_DIV), .H_RES(800), .V_RES(600), .PIC_W(64), .PIC_H(64),
    .FLY_DX(1), .GRAV(GRAV), .HIT_MS(HIT_MS), .DOWN_MS(DOWN_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .mouse_left(mouse_left), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos), .ypos(ypos), .state(state), .hit(hit), .landed(landed), .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; mouse_left = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic spawn(input int x, input int y);
    spawn_x = 12'(x); spawn_y = 12'(y); start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, xpos, ypos, hit, landed, busy} !== 30'd0) begin
      errors++;
      $display("FAIL reset_async: state=%0d x=%0d y=%0d hit=%0b landed=%0b busy=%0b expected all 0",
               state, xpos, ypos, hit, landed, busy);
    end
    step(2);
    rst_n = 1'b1;
    step(12);
    checks++;
    if ({state, xpos, ypos, busy} !== 28'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d x=%0d y=%0d busy=%0b expected 0/0/0/0", state, xpos, ypos, busy);
    end
  endtask

  task automatic test_spawn_fly;
    int e, gap;
    do_reset;
    spawn(100, 50);
    checks++;
    if ({state, xpos, ypos, busy} !== {3'd1, 12'd100, 12'd50, 1'b1}) begin
      errors++;
      $display("FAIL spawn_entry: state=%0d x=%0d y=%0d busy=%0b expected 1/100/50/1", state, xpos, ypos, busy);
    end
    step(9);
    checks++;
    if (xpos !== 12'd100) begin
      errors++;
      $display("FAIL tick_latency: x=%0d expected 100", xpos);
    end
    for (int k = 1; k <= 4; k++) exp_q.push_back(100 + k);
    gap = 1;
    while (exp_q.size() > 0) begin
      step(gap);
      gap = 10;
      e = exp_q.pop_front();
      checks++;
      if ({xpos, ypos} !== {12'(e), 12'd50}) begin
        errors++;
        $display("FAIL fly_step: x=%0d y=%0d expected %0d/50", xpos, ypos, e);
      end
    end
  endtask

  task automatic test_fly_edge;
    int e;
    do_reset;
    spawn(735, 20);
    exp_q.push_back(736); exp_q.push_back(735); exp_q.push_back(734);
    while (exp_q.size() > 0) begin
      step(10);
      e = exp_q.pop_front();
      checks++;
      if (xpos !== 12'(e)) begin
        errors++;
        $display("FAIL right_edge: x=%0d expected %0d", xpos, e);
      end
    end
    do_reset;
    spawn(900, 700);
    checks++;
    if ({xpos, ypos} !== {12'd736, 12'd536}) begin
      errors++;
      $display("FAIL spawn_clamp: x=%0d y=%0d expected 736/536", xpos, ypos);
    end
    exp_q.push_back(736); exp_q.push_back(735);
    while (exp_q.size() > 0) begin
      step(10);
      e = exp_q.pop_front();
      checks++;
      if (xpos !== 12'(e)) begin
        errors++;
        $display("FAIL clamp_reverse: x=%0d expected %0d", xpos, e);
      end
    end
  endtask

  task automatic test_hit_miss;
    int hit_cnt, bad_cnt;
    do_reset;
    spawn(200, 100);
    mouse_xpos = 12'd199; mouse_ypos = 12'd130; mouse_left = 1'b1;
    step(1);
    checks++;
    if ({state, hit} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL miss_left: state=%0d hit=%0b expected 1/0", state, hit);
    end
    mouse_left = 1'b0;
    step(1);
    mouse_xpos = 12'd264; mouse_left = 1'b1;
    step(1);
    checks++;
    if ({state, hit} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL miss_right: state=%0d hit=%0b expected 1/0", state, hit);
    end
    mouse_left = 1'b0;
    mouse_xpos = 12'd230;
    step(5);
    mouse_left = 1'b1;
    step(1);
    checks++;
    if ({state, hit, xpos, ypos} !== {3'd2, 1'b1, 12'd200, 12'd100}) begin
      errors++;
      $display("FAIL hit_on_tick: state=%0d hit=%0b x=%0d y=%0d expected 2/1/200/100", state, hit, xpos, ypos);
    end
    hit_cnt = 0; bad_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (hit) hit_cnt++;
      if ({state, xpos, ypos} !== {3'd2, 12'd200, 12'd100}) bad_cnt++;
    end
    mouse_left = 1'b0;
    checks++;
    if (hit_cnt != 0 || bad_cnt != 0) begin
      errors++;
      $display("FAIL hit_freeze: extra_hits=%0d moved_cycles=%0d expected 0/0", hit_cnt, bad_cnt);
    end
  endtask

  task automatic test_fall_land;
    int vel, yf, e, n, land_cnt;
    logic [11:0] last;
    do_reset;
    spawn(300, 100);
    mouse_xpos = 12'd363; mouse_ypos = 12'd163; mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    checks++;
    if ({state, hit} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL corner_hit: state=%0d hit=%0b expected 2/1", state, hit);
    end
    step(29);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL hit_duration: state=%0d expected 2", state);
    end
    step(1);
    checks++;
    if ({state, ypos} !== {3'd3, 12'd100}) begin
      errors++;
      $display("FAIL fall_entry: state=%0d y=%0d expected 3/100", state, ypos);
    end
    vel = 0; yf = 100 * 256;
    forever begin
      vel = vel + GRAV;
      if (vel > 65535) vel = 65535;
      yf = yf + vel;
      if ((yf >> 8) >= 536) begin
        exp_q.push_back(536);
        break;
      end
      exp_q.push_back(yf >> 8);
    end
    land_cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last = ypos; n = 0;
      do begin
        step(1); n++;
        if (landed) land_cnt++;
      end while (ypos === last && n < 20);
      checks++;
      if (ypos !== 12'(e)) begin
        errors++;
        $display("FAIL fall_y: y=%0d expected %0d after %0d cycles", ypos, e, n);
      end
    end
    checks++;
    if ({state, landed, xpos} !== {3'd4, 1'b1, 12'd300}) begin
      errors++;
      $display("FAIL land_entry: state=%0d landed=%0b x=%0d expected 4/1/300", state, landed, xpos);
    end
    step(5);
    spawn(10, 10);
    checks++;
    if ({state, xpos, ypos, landed} !== {3'd4, 12'd300, 12'd536, 1'b0}) begin
      errors++;
      $display("FAIL down_start_drop: state=%0d x=%0d y=%0d landed=%0b expected 4/300/536/0",
               state, xpos, ypos, landed);
    end
    step(33);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL down_duration: state=%0d expected 4", state);
    end
    step(1);
    checks++;
    if ({state, busy, ypos, land_cnt} !== {3'd0, 1'b0, 12'd536, 32'd1}) begin
      errors++;
      $display("FAIL down_exit: state=%0d busy=%0b y=%0d landed_pulses=%0d expected 0/0/536/1",
               state, busy, ypos, land_cnt);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    spawn(300, 100);
    mouse_xpos = 12'd310; mouse_ypos = 12'd110; mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    step(50);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_fall: state=%0d expected 3", state);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, xpos, ypos, busy} !== 28'd0) begin
      errors++;
      $display("FAIL midfall_reset: state=%0d x=%0d y=%0d busy=%0b expected 0/0/0/0", state, xpos, ypos, busy);
    end
    rst_n = 1'b1;
    step(2);
    spawn(50, 60);
    checks++;
    if ({state, xpos, ypos} !== {3'd1, 12'd50, 12'd60}) begin
      errors++;
      $display("FAIL respawn: state=%0d x=%0d y=%0d expected 1/50/60", state, xpos, ypos);
    end
  endtask

  initial begin
    test_reset;
    test_spawn_fly;
    test_fly_edge;
    test_hit_miss;
    test_fall_land;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
